// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_D;
  logic [REG_AW-1:0] rs2_D;
  logic [REG_AW-1:0] rs1_E;
  logic [REG_AW-1:0] rs2_E;
  logic [REG_AW-1:0] writeReg_E;
  logic [REG_AW-1:0] writeReg_M;
  logic [REG_AW-1:0] writeReg_W;
  logic              regWrite_E;
  logic              regWrite_M;
  logic              regWrite_W;
  logic              isLoad_E;
  logic              pcSrc_E;
  logic              memReq_M;
  logic              memReady;
  logic              stall_F;
  logic              stall_D;
  logic              stall_E;
  logic              stall_M;
  logic              flush_D;
  logic              flush_E;
  logic              flush_W;
  logic [1:0]        forwardA_E;
  logic [1:0]        forwardB_E;
  logic              mem_err;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, writeReg_E, writeReg_M, writeReg_W,
           regWrite_E, regWrite_M, regWrite_W, isLoad_E, pcSrc_E,
           memReq_M, memReady,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           forwardA_E, forwardB_E, mem_err
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, writeReg_E, writeReg_M, writeReg_W,
           regWrite_E, regWrite_M, regWrite_W, isLoad_E, pcSrc_E,
           memReq_M, memReady,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           forwardA_E, forwardB_E, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : stall/flush/forward control for the 5-stage core, with a
//               memory wait FSM and timeout. Optional: HAZARD_FWD_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  wire logic   clk,
  input  wire logic   reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(MEM_TIMEOUT);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_mem_err;
  logic            w_err_set;
  logic            w_dec_hazard;
  logic [3:0]      w_stall;
  logic [2:0]      w_flush;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;

  function automatic logic f_match(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              we);
    return we && (dst != '0) && (dst == src);
  endfunction

`ifdef HAZARD_FWD_EN
  assign w_dec_hazard = hz.isLoad_E &&
                        (f_match(hz.rs1_D, hz.writeReg_E, hz.regWrite_E) ||
                         f_match(hz.rs2_D, hz.writeReg_E, hz.regWrite_E));

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!reset) begin
      if (f_match(hz.rs1_E, hz.writeReg_M, hz.regWrite_M))      w_fwd_a = 2'b10;
      else if (f_match(hz.rs1_E, hz.writeReg_W, hz.regWrite_W)) w_fwd_a = 2'b01;
      if (f_match(hz.rs2_E, hz.writeReg_M, hz.regWrite_M))      w_fwd_b = 2'b10;
      else if (f_match(hz.rs2_E, hz.writeReg_W, hz.regWrite_W)) w_fwd_b = 2'b01;
    end
  end
`else
  // Without forwarding, any in-flight EX/MEM writer of a decode source stalls.
  assign w_dec_hazard = f_match(hz.rs1_D, hz.writeReg_E, hz.regWrite_E) ||
                        f_match(hz.rs2_D, hz.writeReg_E, hz.regWrite_E) ||
                        f_match(hz.rs1_D, hz.writeReg_M, hz.regWrite_M) ||
                        f_match(hz.rs2_D, hz.writeReg_M, hz.regWrite_M);
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  // w_stall = {F, D, E, M}; w_flush = {D, E, W}
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    w_err_set   = 1'b0;
    w_stall     = 4'b0000;
    w_flush     = 3'b000;
    if (reset) begin
      w_state_nxt = RUN;
      w_flush     = 3'b111;
    end else begin
      case (r_state)
        RUN: begin
          if (hz.memReq_M && !hz.memReady) begin
            w_stall     = 4'b1111;
            w_flush     = 3'b001;
            w_state_nxt = MEM_WAIT;
            w_cnt_nxt   = TO_W'(1);
          end else if (hz.pcSrc_E) begin
            w_flush = 3'b110;
          end else if (w_dec_hazard) begin
            w_stall = 4'b1100;
            w_flush = 3'b010;
          end
        end
        MEM_WAIT: begin
          if (hz.memReady) begin
            w_state_nxt = RUN;
          end else if (r_wait_cnt == C_TIMEOUT) begin
            w_err_set   = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_stall   = 4'b1111;
            w_flush   = 3'b001;
            w_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign hz.stall_F    = w_stall[3];
  assign hz.stall_D    = w_stall[2];
  assign hz.stall_E    = w_stall[1];
  assign hz.stall_M    = w_stall[0];
  assign hz.flush_D    = w_flush[2];
  assign hz.flush_E    = w_flush[1];
  assign hz.flush_W    = w_flush[0];
  assign hz.forwardA_E = w_fwd_a;
  assign hz.forwardB_E = w_fwd_b;
  assign hz.mem_err    = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : randomized + directed scoreboard bench for hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

  hazard_ctrl #(
    .REG_AW(REG_AW),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
  );

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, wr_E, wr_M, wr_W;
    logic       we_E, we_M, we_W, ld_E, br_E, req_M, rdy;
  } stim_t;

  // stall = {F,D,E,M}, flush = {D,E,W}
  typedef struct packed {
    logic [3:0] stall;
    logic [2:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } resp_t;

  resp_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // Reference model state: is an access outstanding, how many cycles it has
  // stalled the pipe so far, and the sticky error flag.
  bit m_busy    = 1'b0;
  int m_stalled = 0;
  bit m_err     = 1'b0;

  function automatic bit hit(input logic [4:0] src, input logic [4:0] dst,
                             input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic bit dec_stall(input stim_t s);
`ifdef HAZARD_FWD_EN
    return s.ld_E && (hit(s.rs1_D, s.wr_E, s.we_E) || hit(s.rs2_D, s.wr_E, s.we_E));
`else
    return hit(s.rs1_D, s.wr_E, s.we_E) || hit(s.rs2_D, s.wr_E, s.we_E) ||
           hit(s.rs1_D, s.wr_M, s.we_M) || hit(s.rs2_D, s.wr_M, s.we_M);
`endif
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stim_t s);
`ifdef HAZARD_FWD_EN
    if (hit(src, s.wr_M, s.we_M)) return 2'b10;
    if (hit(src, s.wr_W, s.we_W)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic predict(input stim_t s, output resp_t e);
    bit blocked;
    e     = '0;
    e.err = m_err;
    if (s.reset) begin
      e.flush   = 3'b111;
      m_busy    = 1'b0;
      m_stalled = 0;
      m_err     = 1'b0;
    end else begin
      if (m_busy) blocked = !s.rdy && (m_stalled < MEM_TIMEOUT);
      else        blocked = s.req_M && !s.rdy;
      if (blocked) begin
        e.stall = 4'b1111;
        e.flush = 3'b001;
      end else if (!m_busy) begin
        if (s.br_E) e.flush = 3'b110;
        else if (dec_stall(s)) begin
          e.stall = 4'b1100;
          e.flush = 3'b010;
        end
      end
      e.fa = fwd_sel(s.rs1_E, s);
      e.fb = fwd_sel(s.rs2_E, s);
      if (blocked) begin
        m_stalled = m_busy ? m_stalled + 1 : 1;
        m_busy    = 1'b1;
      end else if (m_busy) begin
        if (!s.rdy) m_err = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    resp_t e;
    @(posedge clk);
    #1;
    reset         = s.reset;
    hz.rs1_D      = s.rs1_D;
    hz.rs2_D      = s.rs2_D;
    hz.rs1_E      = s.rs1_E;
    hz.rs2_E      = s.rs2_E;
    hz.writeReg_E = s.wr_E;
    hz.writeReg_M = s.wr_M;
    hz.writeReg_W = s.wr_W;
    hz.regWrite_E = s.we_E;
    hz.regWrite_M = s.we_M;
    hz.regWrite_W = s.we_W;
    hz.isLoad_E   = s.ld_E;
    hz.pcSrc_E    = s.br_E;
    hz.memReq_M   = s.req_M;
    hz.memReady   = s.rdy;
    predict(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  initial begin
    resp_t e;
    resp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{stall: {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M},
              flush: {hz.flush_D, hz.flush_E, hz.flush_W},
              fa: hz.forwardA_E, fb: hz.forwardB_E, err: hz.mem_err};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL resp @%0t: actual stall=%b flush=%b fA=%b fB=%b err=%b, required stall=%b flush=%b fA=%b fB=%b err=%b",
                   $time, a.stall, a.flush, a.fa, a.fb, a.err,
                   e.stall, e.flush, e.fa, e.fb, e.err);
        end
      end
    end
  end

  initial begin
    stim_t s;
    stim_t z;
    z = '0;
    reset = 1'b1;
    hz.rs1_D = '0; hz.rs2_D = '0; hz.rs1_E = '0; hz.rs2_E = '0;
    hz.writeReg_E = '0; hz.writeReg_M = '0; hz.writeReg_W = '0;
    hz.regWrite_E = 1'b0; hz.regWrite_M = 1'b0; hz.regWrite_W = 1'b0;
    hz.isLoad_E = 1'b0; hz.pcSrc_E = 1'b0; hz.memReq_M = 1'b0; hz.memReady = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held two cycles, then idle.
    s = z; s.reset = 1'b1;
    apply(s); apply(s);
    apply(z); apply(z);

    // Load-use on x5, then the load moves on to MEM.
    s = z; s.ld_E = 1'b1; s.we_E = 1'b1; s.wr_E = 5'd5; s.rs1_D = 5'd5;
    apply(s);
    s = z; s.we_M = 1'b1; s.wr_M = 5'd5; s.rs1_D = 5'd5;
    apply(s);
    s = z; s.ld_E = 1'b1; s.we_E = 1'b1; s.wr_E = 5'd5; s.rs1_D = 5'd0;
    apply(s);
    s = z; s.ld_E = 1'b1; s.we_E = 1'b1; s.wr_E = 5'd0; s.rs2_D = 5'd0;
    apply(s);

    // Memory waits three cycles, ready on the fourth.
    s = z; s.req_M = 1'b1;
    repeat (3) apply(s);
    s.rdy = 1'b1; apply(s);
    apply(z);

    // Branch beats a concurrent load-use.
    s = z; s.br_E = 1'b1; s.ld_E = 1'b1; s.we_E = 1'b1; s.wr_E = 5'd9; s.rs2_D = 5'd9;
    apply(s);

    // Branch held in EX while memory waits: flush deferred past release.
    s = z; s.br_E = 1'b1; s.req_M = 1'b1;
    repeat (2) apply(s);
    s.rdy = 1'b1; apply(s);
    s = z; s.br_E = 1'b1; apply(s);
    apply(z);

    // Forwarding / RAW cases.
    s = z; s.we_M = 1'b1; s.wr_M = 5'd7; s.we_W = 1'b1; s.wr_W = 5'd7; s.rs1_E = 5'd7;
    apply(s);
    s.wr_M = 5'd3; apply(s);
    s = z; s.we_M = 1'b1; s.wr_M = 5'd7; s.rs2_D = 5'd7; s.rs2_E = 5'd7;
    apply(s);

    // Timeout: memReady never comes; error stays until reset.
    s = z; s.req_M = 1'b1;
    repeat (MEM_TIMEOUT + 1) apply(s);
    repeat (3) apply(z);

    // Reset in the middle of a wait aborts it and clears the error.
    s = z; s.req_M = 1'b1;
    repeat (2) apply(s);
    s.reset = 1'b1; apply(s);
    apply(z); apply(z);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      s = z;
      s.reset = ($urandom_range(0, 99) == 0);
      s.rs1_D = 5'($urandom_range(0, 7));
      s.rs2_D = 5'($urandom_range(0, 7));
      s.rs1_E = 5'($urandom_range(0, 7));
      s.rs2_E = 5'($urandom_range(0, 7));
      s.wr_E  = 5'($urandom_range(0, 7));
      s.wr_M  = 5'($urandom_range(0, 7));
      s.wr_W  = 5'($urandom_range(0, 7));
      s.we_E  = 1'($urandom_range(0, 1));
      s.we_M  = 1'($urandom_range(0, 1));
      s.we_W  = 1'($urandom_range(0, 1));
      s.ld_E  = ($urandom_range(0, 2) == 0);
      s.br_E  = ($urandom_range(0, 7) == 0);
      s.req_M = ($urandom_range(0, 3) == 0);
      s.rdy   = ($urandom_range(0, 3) != 0);
      apply(s);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipelined core.
- Drives hold (stall) and bubble (flush) controls into the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses with a wait FSM and timeout.
- Handles load-use hazards and taken-branch flushes.

Parameters:
- REG_AW, 5: register address width.
- MEM_TIMEOUT, 15: max MEM_WAIT cycles before forced release (1..255).
- TO_W, 8: timeout counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs1_D, rs2_D  in  REG_AW  decode-stage source registers.
- rs1_E, rs2_E  in  REG_AW  EX-stage source registers.
- writeReg_E, writeReg_M, writeReg_W  in  REG_AW  destination register per stage.
- regWrite_E, regWrite_M, regWrite_W  in  1  destination valid per stage.
- isLoad_E  in  1  EX-stage instruction is a load.
- pcSrc_E  in  1  taken branch/jump resolved in EX.
- memReq_M  in  1  load/store in MEM stage.
- memReady  in  1  data memory completes the access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1  hold PC / IF_ID / ID_EX / EX_MEM.
- flush_D, flush_E, flush_W  out  1  bubble into IF_ID / ID_EX / MEM_WB.
- forwardA_E, forwardB_E  out  2  00 = regfile, 10 = MEM ALUResult, 01 = WB result.
- mem_err  out  1  sticky: timeout occurred.

Behaviour:
- State register: RUN, MEM_WAIT. Timeout counter wait_cnt[TO_W-1:0]. mem_err is registered. All other outputs are combinational from state and inputs.
- While reset is high: state=RUN, wait_cnt=0, mem_err=0. Outputs: all stalls=0, flush_D/E/W=1, forwards=00.
- A register "matches" only if its address is nonzero and its regWrite is 1. x0 never hazards.
- RUN, memReq_M=1 and memReady=0:
  - Next state MEM_WAIT, wait_cnt reset to 1.
  - Same cycle: stall_F/D/E/M=1, flush_W=1.
- RUN, memReq_M=1 and memReady=1: single-cycle access, no memory stall.
- MEM_WAIT:
  - Outputs: stall_F/D/E/M=1, flush_W=1, flush_D=flush_E=0. Branch and load-use logic are suppressed.
  - memReady=1: return to RUN. That cycle all memory stalls deassert and flush_W=0, so MEM_WB captures the result.
  - Otherwise wait_cnt increments. When wait_cnt==MEM_TIMEOUT and memReady=0: set mem_err, release exactly as for memReady, return to RUN. readData is then undefined.
- mem_err clears only on reset.
- RUN, no memory stall, priority (highest first):
  1. pcSrc_E=1: flush_D=1, flush_E=1, no stall. This overrides any concurrent load-use stall.
  2. Load-use: isLoad_E and writeReg_E matches rs1_D or rs2_D → stall_F=1, stall_D=1, flush_E=1. Stall is exactly one cycle.
  3. Otherwise all stalls and flushes are 0.
- A branch held in EX during MEM_WAIT is acted on in the first RUN cycle after release.
- The register file is write-first, so a WB-stage writer never requires a decode stall.
- Memory stall takes priority over all other hazards. A reset asserted mid-MEM_WAIT aborts to RUN immediately.

Optional Feature:
- HAZARD_FWD_EN defined:
  - forwardA_E = 10 if writeReg_M matches rs1_E; else 01 if writeReg_W matches rs1_E; else 00. MEM has priority over WB.
  - forwardB_E is the same using rs2_E.
  - Decode stalls only for load-use.
- HAZARD_FWD_EN undefined:
  - forwardA_E = forwardB_E = 00 always.
  - RAW stall replaces load-use: if writeReg_E or writeReg_M matches rs1_D or rs2_D, then stall_F=1, stall_D=1, flush_E=1. The stall repeats each cycle until no match.
  - Branch priority is unchanged.

Test Plan:
- Reset held 2 cycles → stalls=0, flush_D/E/W=1, mem_err=0. After release, flushes=0.
- Load x5 in EX with rs1_D=5 → exactly one cycle of stall_F/D=1 and flush_E=1. Same case with rs1_D=0 → no stall.
- memReq_M=1, memReady low for 3 cycles then high → stall_F/D/E/M=1 and flush_W=1 for 3 cycles. On the 4th cycle all are 0 and state=RUN.
- memReady never asserted, MEM_TIMEOUT=15 → release after 15 stalled cycles, mem_err=1 and stays 1 until reset.
- pcSrc_E=1 together with a load-use match → flush_D=flush_E=1, stall_F=stall_D=0. With memory waiting, flush is deferred until release.
- HAZARD_FWD_EN: writeReg_M=7 and writeReg_W=7, rs1_E=7 → forwardA_E=10. With writeReg_M=3 → forwardA_E=01. Undefined macro: writeReg_M=7, rs2_D=7 → stall_D=1, forwards=00.
